// File: rtl/vga_timing_gen_pkg.sv
// Shared 640x480@60 timing constants and helpers for the VGA timing generator.
package vga_timing_gen_pkg;

    // Coordinate / counter width; totals up to 1024 fit in 10 bits
    localparam int unsigned COORD_W = 10;
    localparam int unsigned FRAME_W = 16;
    localparam int unsigned CNT_MAX = 1024;

    // 640x480@60 horizontal timing (pixels)
    localparam int unsigned H_VISIBLE_DEF = 640;
    localparam int unsigned H_FRONT_DEF   = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BACK_DEF    = 48;

    // 640x480@60 vertical timing (lines)
    localparam int unsigned V_VISIBLE_DEF = 480;
    localparam int unsigned V_FRONT_DEF   = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BACK_DEF    = 33;

    // Drive level of a sync line given whether it is in its pulse and the active polarity
    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// VGA timing generator: h/v counters with registered sync, data enable, coordinates and pulses.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
    parameter int unsigned H_FRONT   = H_FRONT_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BACK    = H_BACK_DEF,
    parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
    parameter int unsigned V_FRONT   = V_FRONT_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BACK    = V_BACK_DEF,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               ce,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               frame_start,
    output logic               line_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Counter-domain boundaries
    localparam logic [COORD_W-1:0] H_LAST    = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST    = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS_END = COORD_W'(H_VISIBLE);
    localparam logic [COORD_W-1:0] V_VIS_END = COORD_W'(V_VISIBLE);
    localparam logic [COORD_W-1:0] H_SYNC_LO = COORD_W'(H_VISIBLE + H_FRONT);
    localparam logic [COORD_W-1:0] H_SYNC_HI = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [COORD_W-1:0] V_SYNC_LO = COORD_W'(V_VISIBLE + V_FRONT);
    localparam logic [COORD_W-1:0] V_SYNC_HI = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);

    // Totals must fit the 10-bit counters
    if ((H_TOTAL > CNT_MAX) || (V_TOTAL > CNT_MAX)) begin : g_total_check
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed counter range");
    end

    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;

    logic h_wrap_c;
    logic v_wrap_c;
    logic vis_c;
    logic hs_act_c;
    logic vs_act_c;
    logic h_zero_c;
    logic v_zero_c;

    // Decode of the current counter position
    always_comb begin
        h_wrap_c = (h_cnt == H_LAST);
        v_wrap_c = (v_cnt == V_LAST);
        vis_c    = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
        hs_act_c = (h_cnt >= H_SYNC_LO) && (h_cnt < H_SYNC_HI);
        vs_act_c = (v_cnt >= V_SYNC_LO) && (v_cnt < V_SYNC_HI);
        h_zero_c = (h_cnt == '0);
        v_zero_c = (v_cnt == '0);
    end

    // Horizontal pixel counter, advances on every enabled pixel clock
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            h_cnt <= '0;
        end else if (ce) begin
            h_cnt <= h_wrap_c ? '0 : h_cnt + COORD_W'(1);
        end
    end

    // Vertical line counter, advances when the line wraps
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v_cnt <= '0;
        end else if (ce && h_wrap_c) begin
            v_cnt <= v_wrap_c ? '0 : v_cnt + COORD_W'(1);
        end
    end

    // Output register: one cycle behind the counters, held while ce is low
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            frame_cnt   <= '0;
        end else if (ce) begin
            hsync       <= sync_level(hs_act_c, SYNC_POL);
            vsync       <= sync_level(vs_act_c, SYNC_POL);
            de          <= vis_c;
            x           <= vis_c ? h_cnt : '0;
            y           <= vis_c ? v_cnt : '0;
            frame_start <= h_zero_c && v_zero_c;
            line_start  <= h_zero_c;
            if (h_wrap_c && v_wrap_c) begin
                frame_cnt <= frame_cnt + FRAME_W'(1);
            end
        end else begin
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: reference model feeds a scoreboard queue, three instances checked each cycle.
module tb_vga_timing_gen;

    typedef struct packed {
        logic        hsync;
        logic        vsync;
        logic        de;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        fs;
        logic        ls;
        logic [15:0] fc;
    } obs_t;

    typedef struct {
        int hv, hf, hs, hb, vv, vf, vs, vb;
        bit pol;
    } cfg_t;

    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic resetn;
    logic ce;

    logic        hsync_o  [NDUT];
    logic        vsync_o  [NDUT];
    logic        de_o     [NDUT];
    logic [9:0]  x_o      [NDUT];
    logic [9:0]  y_o      [NDUT];
    logic        fs_o     [NDUT];
    logic        ls_o     [NDUT];
    logic [15:0] fc_o     [NDUT];
    obs_t        obs      [NDUT];

    cfg_t cfg    [NDUT];
    int   m_h    [NDUT];
    int   m_v    [NDUT];
    obs_t m_prev [NDUT];
    obs_t sb     [$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Small 25x13 timing, active-low syncs
    vga_timing_gen #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
        .V_VISIBLE(6),  .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .SYNC_POL(1'b0)
    ) u_small (
        .clk(clk), .resetn(resetn), .ce(ce),
        .hsync(hsync_o[0]), .vsync(vsync_o[0]), .de(de_o[0]),
        .x(x_o[0]), .y(y_o[0]), .frame_start(fs_o[0]),
        .line_start(ls_o[0]), .frame_cnt(fc_o[0])
    );

    // Default 640x480@60 timing
    vga_timing_gen u_dflt (
        .clk(clk), .resetn(resetn), .ce(ce),
        .hsync(hsync_o[1]), .vsync(vsync_o[1]), .de(de_o[1]),
        .x(x_o[1]), .y(y_o[1]), .frame_start(fs_o[1]),
        .line_start(ls_o[1]), .frame_cnt(fc_o[1])
    );

    // Small timing, active-high syncs
    vga_timing_gen #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
        .V_VISIBLE(6),  .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .SYNC_POL(1'b1)
    ) u_pol (
        .clk(clk), .resetn(resetn), .ce(ce),
        .hsync(hsync_o[2]), .vsync(vsync_o[2]), .de(de_o[2]),
        .x(x_o[2]), .y(y_o[2]), .frame_start(fs_o[2]),
        .line_start(ls_o[2]), .frame_cnt(fc_o[2])
    );

    assign obs[0] = {hsync_o[0], vsync_o[0], de_o[0], x_o[0], y_o[0], fs_o[0], ls_o[0], fc_o[0]};
    assign obs[1] = {hsync_o[1], vsync_o[1], de_o[1], x_o[1], y_o[1], fs_o[1], ls_o[1], fc_o[1]};
    assign obs[2] = {hsync_o[2], vsync_o[2], de_o[2], x_o[2], y_o[2], fs_o[2], ls_o[2], fc_o[2]};

    // Reference model back to reset state
    task automatic model_reset();
        for (int i = 0; i < NDUT; i++) begin
            m_h[i] = 0;
            m_v[i] = 0;
            m_prev[i] = '{hsync: !cfg[i].pol, vsync: !cfg[i].pol, de: 1'b0,
                          x: 10'd0, y: 10'd0, fs: 1'b0, ls: 1'b0, fc: 16'd0};
        end
    endtask

    // Expected registered outputs for one clock of instance i
    task automatic model_cycle(input int i, input bit ce_val);
        obs_t e;
        int ht, vt, hs_lo, vs_lo;
        ht    = cfg[i].hv + cfg[i].hf + cfg[i].hs + cfg[i].hb;
        vt    = cfg[i].vv + cfg[i].vf + cfg[i].vs + cfg[i].vb;
        hs_lo = cfg[i].hv + cfg[i].hf;
        vs_lo = cfg[i].vv + cfg[i].vf;
        e = m_prev[i];
        if (ce_val) begin
            e.de    = (m_h[i] < cfg[i].hv) && (m_v[i] < cfg[i].vv);
            e.x     = e.de ? 10'(m_h[i]) : 10'd0;
            e.y     = e.de ? 10'(m_v[i]) : 10'd0;
            e.hsync = ((m_h[i] >= hs_lo) && (m_h[i] < hs_lo + cfg[i].hs)) ? cfg[i].pol : !cfg[i].pol;
            e.vsync = ((m_v[i] >= vs_lo) && (m_v[i] < vs_lo + cfg[i].vs)) ? cfg[i].pol : !cfg[i].pol;
            e.ls    = (m_h[i] == 0);
            e.fs    = (m_h[i] == 0) && (m_v[i] == 0);
            if ((m_h[i] == ht - 1) && (m_v[i] == vt - 1)) e.fc = e.fc + 16'd1;
            if (m_h[i] == ht - 1) begin
                m_h[i] = 0;
                m_v[i] = (m_v[i] == vt - 1) ? 0 : m_v[i] + 1;
            end else begin
                m_h[i] = m_h[i] + 1;
            end
        end else begin
            e.fs = 1'b0;
            e.ls = 1'b0;
        end
        m_prev[i] = e;
    endtask

    task automatic check_obs(input int i, input obs_t exp_v, input string tag);
        checks++;
        assert (obs[i] === exp_v) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, i, obs[i], exp_v);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One clock: push model expectations, clock, pop and compare
    task automatic step(input bit ce_val, input string tag);
        obs_t e;
        ce = ce_val;
        for (int i = 0; i < NDUT; i++) begin
            model_cycle(i, ce_val);
            sb.push_back(m_prev[i]);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            if (sb.size() == 0) begin
                check_val({tag, "_sb_underflow"}, 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                check_obs(i, e, tag);
            end
        end
    endtask

    // Compare every instance against the reset values
    task automatic check_reset_all(input string tag);
        for (int i = 0; i < NDUT; i++) check_obs(i, m_prev[i], tag);
    endtask

    initial begin
        int   de_cnt, hs_first, hs_last, last_fs, last_ls, ls_gap_checks;
        bit   after_last_vis, last_vis_done, found;

        cfg[0] = '{hv: 16,  hf: 2,  hs: 4,  hb: 3,  vv: 6,   vf: 2,  vs: 2, vb: 3,  pol: 1'b0};
        cfg[1] = '{hv: 640, hf: 16, hs: 96, hb: 48, vv: 480, vf: 10, vs: 2, vb: 33, pol: 1'b0};
        cfg[2] = '{hv: 16,  hf: 2,  hs: 4,  hb: 3,  vv: 6,   vf: 2,  vs: 2, vb: 3,  pol: 1'b1};

        // Power-up reset
        resetn = 1'b0;
        ce     = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_all("reset_state");
        check_val("reset_hsync_pol1", 32'(hsync_o[2]), 32'd0);

        // Release and run 2 default lines (~5 small frames) with ce high
        resetn = 1'b1;
        de_cnt = 0; hs_first = -1; hs_last = -1; last_fs = -1;
        after_last_vis = 1'b0; last_vis_done = 1'b0;
        for (int idx = 0; idx < 1600; idx++) begin
            step(1'b1, "run_ce1");
            if (idx == 0) begin
                check_val("first_fs",    32'(fs_o[0]), 32'd1);
                check_val("first_de",    32'(de_o[0]), 32'd1);
                check_val("first_xy",    32'({x_o[0], y_o[0]}), 32'd0);
                check_val("first_fs_df", 32'(fs_o[1]), 32'd1);
            end
            if (idx < 800) begin
                if (de_o[1]) de_cnt++;
                if (hsync_o[1] == 1'b0) begin
                    if (hs_first < 0) hs_first = idx;
                    hs_last = idx;
                end
            end
            if (fs_o[0]) begin
                if (last_fs >= 0) check_val("fs_period_small", 32'(idx - last_fs), 32'd325);
                last_fs = idx;
            end
            if (after_last_vis) begin
                check_val("after_last_vis_de", 32'(de_o[0]), 32'd0);
                check_val("after_last_vis_xy", 32'({x_o[0], y_o[0]}), 32'd0);
                after_last_vis = 1'b0;
                last_vis_done  = 1'b1;
            end
            if (!last_vis_done && de_o[0] && x_o[0] == 10'd15 && y_o[0] == 10'd5) after_last_vis = 1'b1;
        end
        check_val("dflt_de_per_line", 32'(de_cnt), 32'd640);
        check_val("dflt_hsync_first", 32'(hs_first), 32'd656);
        check_val("dflt_hsync_last",  32'(hs_last),  32'd751);
        check_val("small_frame_cnt",  32'(fc_o[0]), 32'd4);
        check_val("last_vis_seen",    32'(last_vis_done), 32'd1);

        // ce toggling: line period doubles, no pulses on held cycles
        last_ls = -1; ls_gap_checks = 0;
        for (int idx = 0; idx < 160; idx++) begin
            step((idx % 2) == 0, "ce_toggle");
            if (ls_o[0]) begin
                if (last_ls >= 0) begin
                    check_val("ls_period_toggle", 32'(idx - last_ls), 32'd50);
                    ls_gap_checks++;
                end
                last_ls = idx;
            end
        end
        check_val("ls_period_seen", 32'(ls_gap_checks > 0), 32'd1);

        // Run to visible pixel (10,3) on the small instance, then reset mid-frame
        found = 1'b0;
        for (int idx = 0; idx < 400 && !found; idx++) begin
            step(1'b1, "to_mid");
            if (m_prev[0].de && m_prev[0].x == 10'd10 && m_prev[0].y == 10'd3) found = 1'b1;
        end
        check_val("mid_pixel_found", 32'(found), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check_reset_all("async_reset");
        @(posedge clk);
        #1;
        check_reset_all("reset_held");
        resetn = 1'b1;
        step(1'b1, "restart");
        check_val("restart_fs", 32'(fs_o[0]), 32'd1);
        check_val("restart_xy", 32'({de_o[0], x_o[0], y_o[0]}), 32'h0010_0000);
        for (int idx = 0; idx < 60; idx++) step(1'b1, "restart_run");
        check_val("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
